// File: rtl/cache_tag_array_if.sv
// Tag-array access bundle between the cache controller and the tag store.
// master: controller side (lookup/write/flush requests); slave: tag store.
interface cache_tag_array_if #(
  parameter int IDX_W = 5,
  parameter int TAG_W = 24,
  parameter int WAY_W = 1
);
  logic             lookup_i;
  logic [IDX_W-1:0] index_i;
  logic [TAG_W-1:0] tag_i;
  logic             rdy_o;
  logic             hit_o;
  logic [WAY_W-1:0] hit_way_o;
  logic             hit_dirty_o;
  logic [WAY_W-1:0] victim_way_o;
  logic             victim_valid_o;
  logic             victim_dirty_o;
  logic [TAG_W-1:0] victim_tag_o;
  logic             write_i;
  logic [IDX_W-1:0] wr_index_i;
  logic [WAY_W-1:0] wr_way_i;
  logic             wr_valid_i;
  logic             wr_dirty_i;
  logic [TAG_W-1:0] wr_tag_i;
  logic             flush_i;
  logic             busy_o;

  modport master (
    output lookup_i, index_i, tag_i,
    output write_i, wr_index_i, wr_way_i,
    output wr_valid_i, wr_dirty_i, wr_tag_i,
    output flush_i,
    input  rdy_o, hit_o, hit_way_o, hit_dirty_o,
    input  victim_way_o, victim_valid_o,
    input  victim_dirty_o, victim_tag_o,
    input  busy_o
  );

  modport slave (
    input  lookup_i, index_i, tag_i,
    input  write_i, wr_index_i, wr_way_i,
    input  wr_valid_i, wr_dirty_i, wr_tag_i,
    input  flush_i,
    output rdy_o, hit_o, hit_way_o, hit_dirty_o,
    output victim_way_o, victim_valid_o,
    output victim_dirty_o, victim_tag_o,
    output busy_o
  );
endinterface

// File: rtl/cache_tag_array.sv
// Set-associative tag store: registered lookup, write port, flush sweep.
// Ports: clk_i, rst_i (sync, active-low), bus (cache_tag_array_if.slave).
// Option CACHE_TAG_PLRU_EN: per-set tree pseudo-LRU, else global round-robin.
module cache_tag_array #(
  parameter int NUM_SETS = 32,
  parameter int TAG_W    = 24,
  parameter int WAYS     = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  cache_tag_array_if.slave   bus
);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t state, state_nx;
  logic             busy;
  logic [IDX_W-1:0] cnt;

  logic             valid_mem [NUM_SETS][WAYS];
  logic             dirty_mem [NUM_SETS][WAYS];
  logic [TAG_W-1:0] tag_mem   [NUM_SETS][WAYS];

  logic             lk_acc, wr_acc;
  logic             hit, hit_dirty;
  logic [WAY_W-1:0] hit_way;
  logic             inv_found;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] repl_way;
  logic [WAY_W-1:0] victim;

  always_ff @(posedge clk_i) begin
    if (!rst_i) state <= FLUSH;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (bus.flush_i) state_nx = FLUSH;
      FLUSH: if (cnt == IDX_W'(NUM_SETS - 1)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == FLUSH);
  end

  assign bus.busy_o = busy;
  assign lk_acc = bus.lookup_i && !busy;
  assign wr_acc = bus.write_i && !busy;

  // Sweep counter parks at 0 in IDLE so a new flush starts at set 0.
  always_ff @(posedge clk_i) begin
    if (!rst_i)              cnt <= '0;
    else if (state == IDLE)  cnt <= '0;
    else                     cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      if (busy) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_mem[cnt][w] <= 1'b0;
          dirty_mem[cnt][w] <= 1'b0;
        end
      end else if (wr_acc) begin
        valid_mem[bus.wr_index_i][bus.wr_way_i] <= bus.wr_valid_i;
        dirty_mem[bus.wr_index_i][bus.wr_way_i] <= bus.wr_dirty_i;
        tag_mem[bus.wr_index_i][bus.wr_way_i]   <= bus.wr_tag_i;
      end
    end
  end

  // Descending scans so the lowest-numbered way wins.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    hit_dirty = 1'b0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_mem[bus.index_i][w] &&
          tag_mem[bus.index_i][w] == bus.tag_i) begin
        hit       = 1'b1;
        hit_way   = WAY_W'(w);
        hit_dirty = dirty_mem[bus.index_i][w];
      end
      if (!valid_mem[bus.index_i][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    victim = inv_found ? inv_way : repl_way;
  end

`ifdef CACHE_TAG_PLRU_EN
  localparam int PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;
  localparam int N1     = (PLRU_W > 1) ? 1 : 0;
  localparam int N2     = PLRU_W - 1;

  logic [PLRU_W-1:0] plru [NUM_SETS];
  logic [PLRU_W-1:0] wr_base, wr_plru;

  // Node bit 0 = left (lower ways), 1 = right; bits point away from MRU.
  function automatic logic [PLRU_W-1:0] touch(
    input logic [PLRU_W-1:0] b,
    input logic [WAY_W-1:0]  w
  );
    logic [PLRU_W-1:0] n;
    n = b;
    if (WAYS == 2) begin
      n[0] = ~w[0];
    end else if (WAYS == 4) begin
      n[0] = ~w[WAY_W-1];
      if (w[WAY_W-1]) n[N2] = ~w[0];
      else            n[N1] = ~w[0];
    end
    return n;
  endfunction

  function automatic logic [WAY_W-1:0] pick(
    input logic [PLRU_W-1:0] b
  );
    logic [WAY_W-1:0] v;
    v = '0;
    if (WAYS == 2) begin
      v[0] = b[0];
    end else if (WAYS == 4) begin
      v[WAY_W-1] = b[0];
      v[0]       = b[0] ? b[N2] : b[N1];
    end
    return v;
  endfunction

  assign repl_way = pick(plru[bus.index_i]);

  // A same-set write is applied on top of the hit update.
  always_comb begin
    wr_base = plru[bus.wr_index_i];
    if (lk_acc && hit && bus.index_i == bus.wr_index_i)
      wr_base = touch(wr_base, hit_way);
    wr_plru = touch(wr_base, bus.wr_way_i);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int s = 0; s < NUM_SETS; s++) plru[s] <= '0;
    end else if (busy) begin
      plru[cnt] <= '0;
    end else begin
      if (lk_acc && hit)
        plru[bus.index_i] <= touch(plru[bus.index_i], hit_way);
      if (wr_acc && bus.wr_valid_i)
        plru[bus.wr_index_i] <= wr_plru;
    end
  end
`else
  logic [WAY_W-1:0] rr;

  assign repl_way = (WAYS == 1) ? '0 : rr;

  always_ff @(posedge clk_i) begin
    if (!rst_i)                        rr <= '0;
    else if (wr_acc && bus.wr_valid_i) rr <= rr + 1'b1;
  end
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      bus.rdy_o          <= 1'b0;
      bus.hit_o          <= 1'b0;
      bus.hit_way_o      <= '0;
      bus.hit_dirty_o    <= 1'b0;
      bus.victim_way_o   <= '0;
      bus.victim_valid_o <= 1'b0;
      bus.victim_dirty_o <= 1'b0;
      bus.victim_tag_o   <= '0;
    end else begin
      bus.rdy_o <= lk_acc;
      if (lk_acc) begin
        bus.hit_o          <= hit;
        bus.hit_way_o      <= hit_way;
        bus.hit_dirty_o    <= hit_dirty;
        bus.victim_way_o   <= victim;
        bus.victim_valid_o <= valid_mem[bus.index_i][victim];
        bus.victim_dirty_o <= dirty_mem[bus.index_i][victim];
        bus.victim_tag_o   <= tag_mem[bus.index_i][victim];
      end
    end
  end
endmodule

// File: tb/tb_cache_tag_array.sv
// Randomized scoreboard bench for cache_tag_array against an LRU-level model.
// Stimulus pushes predictions; a negedge monitor pops and compares.
module tb_cache_tag_array;
  localparam int NUM_SETS = 32;
  localparam int TAG_W    = 24;
  localparam int WAYS     = 2;
  localparam int IDX_W    = 5;
  localparam int WAY_W    = 1;

  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  cache_tag_array_if #(
    .IDX_W(IDX_W), .TAG_W(TAG_W), .WAY_W(WAY_W)
  ) bus ();

  cache_tag_array #(
    .NUM_SETS(NUM_SETS), .TAG_W(TAG_W), .WAYS(WAYS)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .bus(bus)
  );

  typedef struct {
    bit               hit;
    int               hit_way;
    bit               hit_dirty;
    int               vway;
    bit               vvalid;
    bit               vdirty;
    logic [TAG_W-1:0] vtag;
  } exp_t;

  bit               m_valid [NUM_SETS][WAYS];
  bit               m_dirty [NUM_SETS][WAYS];
  logic [TAG_W-1:0] m_tag   [NUM_SETS][WAYS];
  int               m_mru   [NUM_SETS];
  int               m_rr;
  int               m_busy;

  exp_t q[$];
  exp_t me;
  int total = 0;
  int bad   = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Fresh array state: everything invalid, way 0 is the LRU of each set.
  task automatic model_clear();
    for (int s = 0; s < NUM_SETS; s++) begin
      m_mru[s] = 1;
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
      end
    end
  endtask

  function automatic exp_t predict(int idx, logic [TAG_W-1:0] tg);
    exp_t e;
    e.hit = 1'b0; e.hit_way = 0; e.hit_dirty = 1'b0;
    for (int w = 0; w < WAYS; w++)
      if (!e.hit && m_valid[idx][w] && m_tag[idx][w] == tg) begin
        e.hit = 1'b1; e.hit_way = w; e.hit_dirty = m_dirty[idx][w];
      end
    e.vway = -1;
    for (int w = 0; w < WAYS; w++)
      if (e.vway < 0 && !m_valid[idx][w]) e.vway = w;
    if (e.vway < 0) begin
`ifdef CACHE_TAG_PLRU_EN
      e.vway = 1 - m_mru[idx];
`else
      e.vway = m_rr;
`endif
    end
    e.vvalid = m_valid[idx][e.vway];
    e.vdirty = m_dirty[idx][e.vway];
    e.vtag   = m_tag[idx][e.vway];
    return e;
  endfunction

  task automatic op(bit lk, int idx, logic [TAG_W-1:0] tg,
                    bit wr, int widx, int wway, bit wv, bit wd,
                    logic [TAG_W-1:0] wt, bit fl);
    exp_t e;
    bit acc;
    bus.lookup_i   = lk;
    bus.index_i    = IDX_W'(idx);
    bus.tag_i      = tg;
    bus.write_i    = wr;
    bus.wr_index_i = IDX_W'(widx);
    bus.wr_way_i   = WAY_W'(wway);
    bus.wr_valid_i = wv;
    bus.wr_dirty_i = wd;
    bus.wr_tag_i   = wt;
    bus.flush_i    = fl;
    acc = (m_busy == 0);
    chk("busy", {31'b0, bus.busy_o}, acc ? 32'd0 : 32'd1);
    if (lk && acc) e = predict(idx, tg);
    @(posedge clk);
    if (acc) begin
      if (lk && e.hit) m_mru[idx] = e.hit_way;
      if (wr) begin
        m_valid[widx][wway] = wv;
        m_dirty[widx][wway] = wd;
        m_tag[widx][wway]   = wt;
        if (wv) begin
          m_mru[widx] = wway;
          m_rr = (m_rr + 1) % WAYS;
        end
      end
      if (fl) begin
        m_busy = NUM_SETS;
        model_clear();
      end
    end else begin
      m_busy--;
    end
    if (lk && acc) q.push_back(e);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) op(0, 0, '0, 0, 0, 0, 0, 0, '0, 0);
  endtask

  task automatic look(int idx, logic [TAG_W-1:0] tg);
    op(1, idx, tg, 0, 0, 0, 0, 0, '0, 0);
  endtask

  task automatic wrt(int idx, int way, bit v, bit d, logic [TAG_W-1:0] t);
    op(0, 0, '0, 1, idx, way, v, d, t, 0);
  endtask

  always @(negedge clk) begin
    if (rst_i === 1'b1) begin
      if (bus.rdy_o === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_rdy", {31'b0, bus.rdy_o}, 32'd0);
        end else begin
          me = q.pop_front();
          chk("hit", {31'b0, bus.hit_o}, {31'b0, me.hit});
          chk("hit_way", {31'b0, bus.hit_way_o}, me.hit_way);
          chk("hit_dirty", {31'b0, bus.hit_dirty_o}, {31'b0, me.hit_dirty});
          chk("victim_way", {31'b0, bus.victim_way_o}, me.vway);
          chk("victim_valid", {31'b0, bus.victim_valid_o},
              {31'b0, me.vvalid});
          if (me.vvalid) begin
            chk("victim_dirty", {31'b0, bus.victim_dirty_o},
                {31'b0, me.vdirty});
            chk("victim_tag", {8'b0, bus.victim_tag_o}, {8'b0, me.vtag});
          end
        end
      end else if (q.size() != 0) begin
        chk("missing_rdy", {31'b0, bus.rdy_o}, 32'd1);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    rst_i = 1'b0;
    bus.lookup_i = 0; bus.index_i = '0; bus.tag_i = '0;
    bus.write_i = 0; bus.wr_index_i = '0; bus.wr_way_i = '0;
    bus.wr_valid_i = 0; bus.wr_dirty_i = 0; bus.wr_tag_i = '0;
    bus.flush_i = 0;
    for (int s = 0; s < NUM_SETS; s++)
      for (int w = 0; w < WAYS; w++) m_tag[s][w] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy", {31'b0, bus.rdy_o}, 32'd0);
    chk("rst_hit", {31'b0, bus.hit_o}, 32'd0);
    chk("rst_hit_way", {31'b0, bus.hit_way_o}, 32'd0);
    chk("rst_victim_way", {31'b0, bus.victim_way_o}, 32'd0);
    chk("rst_victim_valid", {31'b0, bus.victim_valid_o}, 32'd0);
    chk("rst_busy", {31'b0, bus.busy_o}, 32'd1);
    rst_i = 1'b1;
    m_busy = NUM_SETS;
    m_rr = 0;
    model_clear();

    // Lookups during the post-reset sweep must be ignored.
    for (int i = 0; i < NUM_SETS; i++)
      look($urandom_range(0, NUM_SETS - 1), TAG_W'($urandom));
    idle(1);

    wrt(5, 1, 1, 1, 24'hABCDEF);
    look(5, 24'hABCDEF);
    wrt(5, 0, 0, 0, 24'h000001);
    look(5, 24'h000001);

    op(1, 7, 24'h123456, 1, 7, 0, 1, 0, 24'h123456, 0);
    look(7, 24'h123456);

`ifdef CACHE_TAG_PLRU_EN
    wrt(3, 0, 1, 0, 24'h00AAAA);
    wrt(3, 1, 1, 1, 24'h00BBBB);
    look(3, 24'h00AAAA);
    look(3, 24'h00CCCC);
`endif

    for (int i = 0; i < 600; i++) begin
      op($urandom_range(0, 9) < 6, $urandom_range(0, 3),
         TAG_W'($urandom_range(0, 3)),
         $urandom_range(0, 9) < 4, $urandom_range(0, 3),
         $urandom_range(0, WAYS - 1), $urandom_range(0, 7) != 0,
         $urandom_range(0, 1), TAG_W'($urandom_range(0, 3)),
         $urandom_range(0, 99) == 0);
    end
    idle(NUM_SETS + 1);

    for (int s = 0; s < NUM_SETS; s++)
      wrt(s, s % WAYS, 1, s % 3 == 0, TAG_W'(32'h100 + s));
    for (int s = 0; s < NUM_SETS; s += 8)
      look(s, TAG_W'(32'h100 + s));
    op(0, 0, '0, 0, 0, 0, 0, 0, '0, 1);
    for (int i = 0; i < NUM_SETS; i++)
      look(i, TAG_W'(32'h100 + i));
    for (int s = 0; s < NUM_SETS; s++)
      look(s, TAG_W'(32'h100 + s));
    idle(3);

    chk("queue_drain", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
